// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared types and constants for the attention head sequencer
// Contents: state_t FSM encoding, err_code values, stage index names,
//           min_width() helper for index/counter widths.

package attn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_SPURIOUS = 2'd2;

  localparam int STG_QKV     = 0;
  localparam int STG_SCORE   = 1;
  localparam int STG_SOFTMAX = 2;
  localparam int STG_PREC    = 3;
  localparam int STG_AV      = 4;
  localparam int STG_WO      = 5;

  // Width needed to index n items, never less than one bit.
  function automatic int min_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage timeout counter
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero the count (stage launch)
//   enable      count this cycle (waiting for stage_done)
//   expired     high during the TIMEOUT_CYCLES-th enabled cycle since clear

module stage_watchdog
  import attn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = min_width(TIMEOUT_CYCLES + 1);
  localparam bit ACTIVE = (TIMEOUT_CYCLES > 0);
  // The count of a waiting cycle equals the number of earlier waiting cycles,
  // so the TIMEOUT_CYCLES-th one is seen when the count equals TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TW'(1);
    end
    expired = ACTIVE && enable && (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/attn_head_sequencer.sv
// rtl/attn_head_sequencer.sv - multi-head self-attention stage sequencer
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        launch a run (accepted in S_IDLE / S_ERROR)
//   abort        cancel the current run
//   stage_done   per-stage done pulses from the engines
//   stage_start  per-stage start pulses to the engines (one-hot or zero)
//   head_idx     head being processed
//   stage_idx    active stage
//   busy         run in progress
//   done         one-cycle completion pulse; out_valid mirrors it
//   error        sticky error flag, err_code / err_stage give the cause
//   cycle_count  saturating cycles spent launching / waiting in the last run

module attn_head_sequencer
  import attn_pkg::*;
#(
  parameter int NUM_HEADS      = 4,
  parameter int NUM_STAGES     = 6,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 32,
  localparam int HW = min_width(NUM_HEADS),
  localparam int SW = min_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [HW-1:0]         head_idx,
  output logic [SW-1:0]         stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [SW-1:0]         err_stage,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam logic [HW-1:0] LAST_HEAD     = HW'(NUM_HEADS - 1);
  localparam logic [SW-1:0] LAST_PH_STAGE = SW'(NUM_STAGES - 2);
  localparam logic [SW-1:0] WO_STAGE      = SW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = {{(NUM_STAGES-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                  state_q, state_d;
  logic [HW-1:0]           head_q, head_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [SW-1:0]           err_stage_q, err_stage_d;
  logic [CNT_W-1:0]        cycle_count_q, cycle_count_d;

  logic [NUM_STAGES-1:0]   cur_bit;
  logic                    wd_expired;

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == S_LAUNCH),
    .enable (state_q == S_WAIT),
    .expired(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    stage_d       = stage_q;
    err_code_d    = err_code_q;
    err_stage_d   = err_stage_q;
    cycle_count_d = cycle_count_q;
    cur_bit       = STAGE_ONE << stage_q;

    if (((state_q == S_LAUNCH) || (state_q == S_WAIT)) && (cycle_count_q != CNT_MAX)) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    if (abort && (state_q != S_IDLE)) begin
      // Abort outranks start and stage_done arriving in the same cycle.
      state_d     = S_IDLE;
      err_code_d  = ERR_NONE;
      err_stage_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_d       = S_LAUNCH;
            head_d        = '0;
            stage_d       = '0;
            err_code_d    = ERR_NONE;
            err_stage_d   = '0;
            cycle_count_d = '0;
          end
        end
        S_LAUNCH: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A foreign done bit is an error even if the expected bit is also set.
          if ((stage_done & ~cur_bit) != '0) begin
            state_d     = S_ERROR;
            err_code_d  = ERR_SPURIOUS;
            err_stage_d = stage_q;
          end else if ((stage_done & cur_bit) != '0) begin
            // Done is checked before the watchdog so a same-cycle done wins.
            if (stage_q == WO_STAGE) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LAUNCH;
              if (stage_q != LAST_PH_STAGE) begin
                stage_d = stage_q + SW'(1);
              end else if (head_q != LAST_HEAD) begin
                head_d  = head_q + HW'(1);
                stage_d = '0;
              end else begin
                stage_d = WO_STAGE;
              end
            end
          end else if (wd_expired) begin
            state_d     = S_ERROR;
            err_code_d  = ERR_TIMEOUT;
            err_stage_d = stage_q;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    busy_d        = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    done_d        = (state_d == S_DONE);
    error_d       = (state_d == S_ERROR);
    stage_start_d = (state_d == S_LAUNCH) ? (STAGE_ONE << stage_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      head_q        <= '0;
      stage_q       <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_stage_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      stage_q       <= stage_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      err_stage_q   <= err_stage_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign stage_start = stage_start_q;
  assign head_idx    = head_q;
  assign stage_idx   = stage_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign err_stage   = err_stage_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_attn_head_sequencer.sv
// tb/tb_attn_head_sequencer.sv - self-checking bench for attn_head_sequencer

module tb_attn_head_sequencer;

  localparam int NH = 4;
  localparam int NS = 6;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start_a, abort_a;
  logic [NS-1:0] stage_done_a, stage_start_a;
  logic [1:0]    head_idx_a;
  logic [2:0]    stage_idx_a, err_stage_a;
  logic          busy_a, done_a, out_valid_a, error_a;
  logic [1:0]    err_code_a;
  logic [31:0]   cycle_count_a;

  logic          start_b, abort_b;
  logic [NS-1:0] stage_done_b, stage_start_b;
  logic [0:0]    head_idx_b;
  logic [2:0]    stage_idx_b, err_stage_b;
  logic          busy_b, done_b, out_valid_b, error_b;
  logic [1:0]    err_code_b;
  logic [31:0]   cycle_count_b;

  attn_head_sequencer #(
    .NUM_HEADS(NH), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .stage_done(stage_done_a), .stage_start(stage_start_a),
    .head_idx(head_idx_a), .stage_idx(stage_idx_a), .busy(busy_a),
    .done(done_a), .out_valid(out_valid_a), .error(error_a),
    .err_code(err_code_a), .err_stage(err_stage_a), .cycle_count(cycle_count_a)
  );

  attn_head_sequencer #(
    .NUM_HEADS(1), .NUM_STAGES(NS), .TIMEOUT_CYCLES(65535), .CNT_W(32)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .stage_done(stage_done_b), .stage_start(stage_start_b),
    .head_idx(head_idx_b), .stage_idx(stage_idx_b), .busy(busy_b),
    .done(done_b), .out_valid(out_valid_b), .error(error_b),
    .err_code(err_code_b), .err_stage(err_stage_b), .cycle_count(cycle_count_b)
  );

  int tests = 0;
  int fails = 0;

  int e, lat, hang_stg, poke_e, spur_e, spur_bit, abort_e;
  int pend_cnt, pend_stg;
  int obs_h[$];
  int obs_s[$];
  int obs_e[$];
  int done_cnt, done_e, err_e;
  logic [31:0] cc_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_knobs();
    hang_stg = -1;
    poke_e   = -99;
    spur_e   = -99;
    spur_bit = 0;
    abort_e  = -99;
  endtask

  // One cycle of DUT A: observe at the falling edge, then drive the engine
  // model (done lat cycles after each start) and the scheduled knobs.
  task automatic step();
    @(negedge clk);
    e++;
    stage_done_a = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0 && pend_stg != hang_stg) stage_done_a[pend_stg] = 1'b1;
    end
    if (stage_start_a != '0) begin
      chk("start_onehot", stage_start_a, NS'(1) << stage_idx_a);
      obs_h.push_back(int'(head_idx_a));
      obs_s.push_back(int'(stage_idx_a));
      obs_e.push_back(e);
      pend_cnt = lat;
      pend_stg = int'(stage_idx_a);
    end
    if (e == spur_e) stage_done_a[spur_bit] = 1'b1;
    if (done_a) begin
      chk("out_valid", out_valid_a, 1);
      done_cnt++;
      done_e  = e;
      cc_done = cycle_count_a;
    end
    if (error_a && err_e < 0) err_e = e;
    start_a = (e == poke_e);
    abort_a = (e == abort_e);
  endtask

  // Pulses start; on return e==0 is the cycle right after the start edge.
  task automatic launch(input int l);
    lat      = l;
    pend_cnt = 0;
    done_cnt = 0;
    done_e   = -1;
    err_e    = -1;
    obs_h.delete();
    obs_s.delete();
    obs_e.delete();
    start_a = 1'b1;
    e = -1;
    step();
  endtask

  task automatic nominal(input int l);
    int n_exp, per, idx;
    per   = l + 1;
    n_exp = NH * (NS - 1) + 1;
    launch(l);
    chk("launch_busy", busy_a, 1);
    chk("launch_clear", {error_a, err_code_a, cycle_count_a}, 0);
    while (done_cnt == 0 && e < 40 * n_exp) step();
    repeat (3) step();
    chk("n_starts", obs_h.size(), n_exp);
    idx = 0;
    for (int h = 0; h < NH; h++) begin
      for (int s = 0; s < NS; s++) begin
        if (s == NS - 1 && h != NH - 1) continue;
        if (idx < obs_h.size())
          chk("order_h_s_cycle", obs_h[idx] * 1000000 + obs_s[idx] * 10000 + obs_e[idx],
              h * 1000000 + s * 10000 + idx * per);
        idx++;
      end
    end
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_e, n_exp * per);
    chk("cycle_count", cc_done, n_exp * per);
    chk("idle_busy", busy_a, 0);
    chk("hold_idx", {head_idx_a, stage_idx_a}, {2'(NH - 1), 3'(NS - 1)});
    chk("no_error", error_a, 0);
  endtask

  initial begin
    int nb, done_eb;
    logic [31:0] ccb;
    logic [NS-1:0] prev;

    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; stage_done_a = '0;
    start_b = 1'b0; abort_b = 1'b0; stage_done_b = '0;
    clear_knobs();
    pend_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_a", {stage_start_a, head_idx_a, stage_idx_a, busy_a, done_a, out_valid_a,
                    error_a, err_code_a, err_stage_a, cycle_count_a}, 0);
    chk("reset_b", {stage_start_b, busy_b, done_b, error_b, cycle_count_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal runs; start poked mid-run must be ignored; lat 10 = done on timeout cycle.
    poke_e = 5;
    nominal(3);
    clear_knobs();
    nominal($urandom_range(1, 9));
    nominal(10);

    // Stage 2 never completes: timeout after TO waiting cycles.
    clear_knobs();
    hang_stg = 2;
    launch(2);
    while (err_e < 0 && e < 200) step();
    chk("to_err_cycle", err_e, 2 * 3 + TO + 1);
    chk("to_code", err_code_a, 1);
    chk("to_stage", err_stage_a, 2);
    chk("to_busy", busy_a, 0);
    repeat (5) step();
    chk("to_no_more_starts", obs_h.size(), 3);
    chk("to_sticky", error_a, 1);
    clear_knobs();
    nominal($urandom_range(1, 5));

    // Foreign done bit during stage 1, possibly with the correct bit.
    clear_knobs();
    spur_e   = 4 + $urandom_range(1, 3);
    spur_bit = $urandom_range(0, 4);
    if (spur_bit >= 1) spur_bit++;
    launch(3);
    while (err_e < 0 && e < 200) step();
    chk("sp_err_cycle", err_e, spur_e + 1);
    chk("sp_code", err_code_a, 2);
    chk("sp_stage", err_stage_a, 1);
    repeat (4) step();
    chk("sp_sticky", {error_a, err_code_a}, {1'b1, 2'd2});
    chk("sp_no_more_starts", obs_h.size(), 2);
    abort_a = 1'b1;
    step();
    chk("sp_abort_clears", {error_a, err_code_a, busy_a}, 0);

    // Abort together with stage_done[4] of head 2.
    clear_knobs();
    lat = $urandom_range(1, 5);
    abort_e = 14 * (lat + 1) + lat;
    launch(lat);
    while (e < abort_e + 1) step();
    chk("ab_busy", busy_a, 0);
    chk("ab_start", stage_start_a, 0);
    chk("ab_error", error_a, 0);
    repeat (20) step();
    chk("ab_starts", obs_h.size(), 15);
    chk("ab_last_hs", obs_h[obs_h.size() - 1] * 10 + obs_s[obs_s.size() - 1], 24);
    chk("ab_no_done", done_cnt, 0);

    // Asynchronous reset mid-run.
    clear_knobs();
    launch(2);
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {stage_start_a, head_idx_a, stage_idx_a, busy_a, done_a,
                      error_a, err_code_a, err_stage_a, cycle_count_a}, 0);
    @(negedge clk);
    stage_done_a = '0;
    rst_n = 1'b1;
    @(negedge clk);
    launch(2);
    chk("rst_restart", stage_start_a, 1);
    while (done_cnt == 0 && e < 400) step();
    chk("rst_done_cycle", done_e, 21 * 3);

    // Single head, engines answering one cycle after each start.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nb = 0; done_eb = -1; ccb = '0; prev = '0;
    for (int k = 0; k < 30; k++) begin
      if (stage_start_b != '0) nb++;
      if (done_b) begin
        done_eb = k;
        ccb     = cycle_count_b;
      end
      stage_done_b = prev;
      prev = stage_start_b;
      @(negedge clk);
    end
    chk("b_starts", nb, 6);
    chk("b_done_cycle", done_eb, 12);
    chk("b_cycle_count", ccb, 12);
    chk("b_idle", {busy_b, error_b}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
